// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply controller for base^exp mod M.
// Drives an external modular multiplier over a start/done handshake.
module modexp_ctrl #(
  parameter int unsigned EXP_W   = 256,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [255:0]     base,
  input  logic [EXP_W-1:0] exp,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [255:0]     result,
  output logic [255:0]     mul_x,
  output logic [255:0]     mul_y,
  output logic             mul_start,
  input  logic             mul_done,
  input  logic [255:0]     mul_q
);

  localparam int unsigned IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] IdxTop  = IDX_W'(EXP_W - 1);
  localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT - 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StScan     = 3'd1;
  localparam logic [2:0] StSqIssue  = 3'd2;
  localparam logic [2:0] StSqWait   = 3'd3;
  localparam logic [2:0] StMulIssue = 3'd4;
  localparam logic [2:0] StMulWait  = 3'd5;
  localparam logic [2:0] StFinish   = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [255:0]     base_q, base_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [255:0]     acc_q, acc_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [255:0]     result_q, result_d;
  logic [255:0]     mul_x_q, mul_x_d;
  logic [255:0]     mul_y_q, mul_y_d;
  logic             mul_start_q, mul_start_d;
  logic             mul_done_q;
  logic             mul_event;
  logic             idx_zero;
  logic             timed_out;

  // Only a rising edge counts, so a done level left over from an earlier call is inert.
  assign mul_event = mul_done & ~mul_done_q;
  assign idx_zero  = (idx_q == '0);
  assign timed_out = (timer_q == TmrLast);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    exp_d       = exp_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    timer_d     = timer_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    result_d    = result_q;
    mul_x_d     = mul_x_q;
    mul_y_d     = mul_y_q;
    mul_start_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          base_d  = base;
          exp_d   = exp;
          idx_d   = IdxTop;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (exp_q[idx_q]) begin
          acc_d = base_q;
          if (idx_zero) begin
            state_d = StFinish;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = StSqIssue;
          end
        end else if (idx_zero) begin
          acc_d   = 256'd1;
          state_d = StFinish;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StSqIssue: begin
        mul_x_d     = acc_q;
        mul_y_d     = acc_q;
        mul_start_d = 1'b1;
        timer_d     = '0;
        state_d     = StSqWait;
      end
      StSqWait: begin
        if (mul_event) begin
          acc_d = mul_q;
          if (exp_q[idx_q]) begin
            state_d = StMulIssue;
          end else if (idx_zero) begin
            state_d = StFinish;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = StSqIssue;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          acc_d   = '0;
          state_d = StFinish;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StMulIssue: begin
        mul_x_d     = acc_q;
        mul_y_d     = base_q;
        mul_start_d = 1'b1;
        timer_d     = '0;
        state_d     = StMulWait;
      end
      StMulWait: begin
        if (mul_event) begin
          acc_d = mul_q;
          if (idx_zero) begin
            state_d = StFinish;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = StSqIssue;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          acc_d   = '0;
          state_d = StFinish;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StFinish: begin
        result_d = acc_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      exp_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      mul_start_q <= 1'b0;
      mul_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      exp_q       <= exp_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      timer_q     <= timer_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      result_q    <= result_d;
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      mul_start_q <= mul_start_d;
      mul_done_q  <= mul_done;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign mul_start = mul_start_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Scoreboard bench for modexp_ctrl with a mod-97 multiplier stub.
module tb_modexp_ctrl;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [255:0]     base = '0;
  logic [EXP_W-1:0] exp = '0;
  logic             busy, done, err, mul_start;
  logic [255:0]     result, mul_x, mul_y;
  logic             mul_done = 1'b0;
  logic [255:0]     mul_q = '0;

  modexp_ctrl #(.EXP_W(EXP_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .exp       (exp),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_start (mul_start),
    .mul_done  (mul_done),
    .mul_q     (mul_q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Multiplier stub: product mod 97 with done raised 5 cycles after mul_start.
  logic [255:0] pend = '0;
  int           cnt = 0;
  bit           hold_mode = 1'b0;
  bit           no_done = 1'b0;

  always @(posedge clk) begin
    if (mul_start) begin
      pend     <= (mul_x * mul_y) % 256'd97;
      cnt      <= 5;
      mul_done <= 1'b0;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1 && !no_done) begin
        mul_done <= 1'b1;
        mul_q    <= pend;
      end else if (!hold_mode) begin
        mul_done <= 1'b0;
      end
    end else if (!hold_mode) begin
      mul_done <= 1'b0;
    end
  end

  typedef struct {
    logic [255:0] x;
    logic [255:0] y;
  } ops_t;

  typedef struct {
    logic [255:0] res;
    logic         err;
    int           calls;
  } res_t;

  ops_t ops_q[$];
  res_t res_q[$];
  ops_t e_op;
  res_t e_res;
  int   checks = 0;
  int   failures = 0;
  int   calls_seen = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Monitor: checks every multiplier call and every completion against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      calls_seen = 0;
    end else begin
      if (mul_start) begin
        calls_seen++;
        checks++;
        if (ops_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_mul_start x=%0d y=%0d", mul_x, mul_y);
        end else begin
          e_op = ops_q.pop_front();
          if (mul_x !== e_op.x || mul_y !== e_op.y) begin
            failures++;
            $display("FAIL mul_operands got x=%0d y=%0d want x=%0d y=%0d",
                     mul_x, mul_y, e_op.x, e_op.y);
          end
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done result=%0d err=%0d", result, err);
        end else begin
          e_res = res_q.pop_front();
          check("result", result, e_res.res);
          check("err", 256'(err), 256'(e_res.err));
          check("call_count", 256'(calls_seen), 256'(e_res.calls));
          check("busy_at_done", 256'(busy), 256'd0);
        end
        calls_seen = 0;
      end
    end
  end

  task automatic push_op(input logic [255:0] x, input logic [255:0] y);
    ops_t o;
    o.x = x;
    o.y = y;
    ops_q.push_back(o);
  endtask

  task automatic push_res(input logic [255:0] r, input logic e, input int calls);
    res_t o;
    o.res   = r;
    o.err   = e;
    o.calls = calls;
    res_q.push_back(o);
  endtask

  task automatic issue(input logic [255:0] b, input logic [EXP_W-1:0] e, output int t0);
    @(negedge clk);
    start = 1'b1;
    base  = b;
    exp   = e;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int t0, output int lat);
    bit seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    lat = cyc - t0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL wait_done got=timeout want=done");
    end
  endtask

  task automatic run_op(input logic [255:0] b, input logic [EXP_W-1:0] e, output int lat);
    int t0;
    issue(b, e, t0);
    wait_done(t0, lat);
  endtask

  task automatic push_exp13_base3();
    push_op(3, 3);
    push_op(9, 3);
    push_op(27, 27);
    push_op(50, 50);
    push_op(75, 3);
    push_res(31, 1'b0, 5);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 256'(busy), 256'd0);
    check({tag, "_done"}, 256'(done), 256'd0);
    check({tag, "_err"}, 256'(err), 256'd0);
    check({tag, "_mul_start"}, 256'(mul_start), 256'd0);
    check({tag, "_result"}, result, 256'd0);
    check({tag, "_mul_x"}, mul_x, 256'd0);
    check({tag, "_mul_y"}, mul_y, 256'd0);
  endtask

  initial begin
    int  lat;
    int  t0;
    bit  seen;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    // exp=0: 8 scan cycles plus capture and FINISH
    push_res(1, 1'b0, 0);
    run_op(5, 8'd0, lat);
    check("latency_exp0", 256'(lat), 256'd10);

    push_res(42, 1'b0, 0);
    run_op(42, 8'd1, lat);

    push_op(5, 5);
    push_op(25, 5);
    push_res(28, 1'b0, 2);
    run_op(5, 8'd3, lat);

    push_exp13_base3();
    run_op(3, 8'd13, lat);

    hold_mode = 1'b1;
    push_exp13_base3();
    run_op(3, 8'd13, lat);
    hold_mode = 1'b0;
    repeat (2) @(negedge clk);

    // Timeout: capture + 7 scan + issue + 16 wait cycles + FINISH
    no_done = 1'b1;
    push_op(5, 5);
    push_res(0, 1'b1, 1);
    run_op(5, 8'd3, lat);
    check("latency_timeout", 256'(lat), 256'd26);
    no_done = 1'b0;
    repeat (8) @(negedge clk);

    push_op(5, 5);
    push_op(25, 5);
    push_res(28, 1'b0, 2);
    run_op(5, 8'd3, lat);

    // Abort in SQ_WAIT; the stale multiplier done then arrives while IDLE.
    push_op(3, 3);
    issue(3, 8'd13, t0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mul_start) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_saw_mul_start", 256'(seen), 256'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_busy_after_stale", 256'(busy), 256'd0);
    check("abort_result_after_stale", result, 256'd0);

    push_op(5, 5);
    push_op(25, 5);
    push_res(28, 1'b0, 2);
    run_op(5, 8'd3, lat);

    // A start while busy must be dropped.
    push_exp13_base3();
    issue(3, 8'd13, t0);
    repeat (12) @(negedge clk);
    start = 1'b1;
    base  = 42;
    exp   = 8'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(t0, lat);
    repeat (5) @(negedge clk);
    check("result_held", result, 256'd31);
    check("idle_after_ignored_start", 256'(busy), 256'd0);

    check("ops_queue_empty", 256'(ops_q.size()), 256'd0);
    check("res_queue_empty", 256'(res_q.size()), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
